fanin_req_arbiter_l2: RTL and testbench

// N-to-1 request fan-in for the L2 crossbar: merges N_CH master request channels onto one L2 bank port.

---
 rtl/fanin_req_arbiter_l2.sv | 193 +++++++++++++++++++
 tb/tb_fanin_req_arbiter_l2.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanin_req_arbiter_l2.sv
// ---------------------------------------------------------------------------
// fanin_req_arbiter_l2
//
// Merges N_CH master request channels onto a single L2 bank port. A
// registered round-robin pointer chooses among the requesting channels.
//
// Optional build macro: FANIN_REQ_L2_OUT_REG_EN
//   undefined : combinational request path. A stalled winner is locked until
//               the bank grants it, so the payload stays stable during a stall.
//   defined   : one-entry output register slice between the arbiter and the
//               bank. The slice keeps the payload stable, so no lock is used.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   data_req_i        per-channel request
//   data_add_i        per-channel address
//   data_wen_i        per-channel write enable (1 = read)
//   data_wdata_i      per-channel write data
//   data_be_i         per-channel byte enables
//   data_ID_i         per-channel transaction ID
//   data_gnt_o        per-channel grant, one-hot or zero
//   data_req_o        merged request to the bank
//   data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o
//                     payload of the winning channel
//   data_gnt_i        grant from the bank
// ---------------------------------------------------------------------------
module fanin_req_arbiter_l2 #(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 16,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_CH-1:0]                      data_req_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      data_add_i,
  input  logic [N_CH-1:0]                      data_wen_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [N_CH-1:0][BE_WIDTH-1:0]        data_be_i,
  input  logic [N_CH-1:0][ID_WIDTH-1:0]        data_ID_i,
  output logic [N_CH-1:0]                      data_gnt_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [ID_WIDTH-1:0]                  data_ID_o,
  input  logic                                 data_gnt_i
);

  localparam int                 LOG_CH  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [LOG_CH-1:0]  LAST_CH = LOG_CH'(N_CH - 1);

  logic [LOG_CH-1:0] rr_q;
  logic [LOG_CH-1:0] rr_win_idx;
  logic [LOG_CH-1:0] winner;
  logic              any_req;

  // Pointer advance with an explicit wrap so that non-power-of-2 channel
  // counts never let the pointer reach an index that does not exist.
  function automatic logic [LOG_CH-1:0] rr_after(input logic [LOG_CH-1:0] w);
    return (w == LAST_CH) ? '0 : w + LOG_CH'(1);
  endfunction

  assign any_req = |data_req_i;

  // Round-robin search: first requester at rr_q, rr_q+1, ... wrapping at
  // N_CH. With nothing requesting the result falls back to rr_q itself so the
  // idle payload is deterministic.
  always_comb begin : rr_search
    logic [LOG_CH-1:0] cand;
    logic              found;
    cand       = '0;
    found      = 1'b0;
    rr_win_idx = rr_q;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(rr_q) + k >= N_CH) begin
        cand = LOG_CH'(int'(rr_q) + k - N_CH);
      end else begin
        cand = LOG_CH'(int'(rr_q) + k);
      end
      if (!found && data_req_i[cand]) begin
        found      = 1'b1;
        rr_win_idx = cand;
      end
    end
  end

`ifdef FANIN_REQ_L2_OUT_REG_EN

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] add_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  up_accept;

  assign winner = rr_win_idx;

  // The slice takes a new beat whenever it is empty or is being drained by
  // the bank in the same cycle, which keeps full throughput under a
  // continuous bank grant.
  assign up_accept = any_req & (~valid_q | data_gnt_i);

  always_comb begin
    data_gnt_o = '0;
    if (up_accept) begin
      data_gnt_o[winner] = 1'b1;
    end
  end

  // Output slice and pointer. The pointer moves on every upstream accept; the
  // slice empties when the bank takes its beat and nothing refills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      valid_q <= 1'b0;
      add_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      id_q    <= '0;
    end else if (up_accept) begin
      rr_q    <= rr_after(winner);
      valid_q <= 1'b1;
      add_q   <= data_add_i[winner];
      wen_q   <= data_wen_i[winner];
      wdata_q <= data_wdata_i[winner];
      be_q    <= data_be_i[winner];
      id_q    <= data_ID_i[winner];
    end else if (data_gnt_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_req_o   = valid_q;
  assign data_add_o   = add_q;
  assign data_wen_o   = wen_q;
  assign data_wdata_o = wdata_q;
  assign data_be_o    = be_q;
  assign data_ID_o    = id_q;

`else

  logic              lock_q;
  logic [LOG_CH-1:0] lock_idx_q;
  logic              lock_hit;
  logic              accept;
  logic              stall;

  // A locked channel keeps the port only while it still requests; if it
  // drops out, normal round-robin takes over in the same cycle.
  assign lock_hit = lock_q & data_req_i[lock_idx_q];
  assign winner   = lock_hit ? lock_idx_q : rr_win_idx;
  assign accept   = any_req & data_gnt_i;
  assign stall    = any_req & ~data_gnt_i;

  always_comb begin
    data_gnt_o = '0;
    if (accept) begin
      data_gnt_o[winner] = 1'b1;
    end
  end

  // Pointer and lock. A stall pins the current winner so its payload stays
  // on the bank port; an accept releases the lock and moves the pointer past
  // the winner. With no request at all the state simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (accept) begin
      rr_q   <= rr_after(winner);
      lock_q <= 1'b0;
    end else if (stall) begin
      lock_q     <= 1'b1;
      lock_idx_q <= winner;
    end
  end

  assign data_req_o   = any_req;
  assign data_add_o   = data_add_i[winner];
  assign data_wen_o   = data_wen_i[winner];
  assign data_wdata_o = data_wdata_i[winner];
  assign data_be_o    = data_be_i[winner];
  assign data_ID_o    = data_ID_i[winner];

`endif

endmodule

// File: tb/tb_fanin_req_arbiter_l2.sv
// ---------------------------------------------------------------------------
// tb_fanin_req_arbiter_l2
//
// Drives a 4-channel instance with directed and randomized traffic and a
// 3-channel instance for the non-power-of-2 pointer wrap. A behavioural model
// (pointer, lock flag / pending beat) predicts every output each cycle.
// Follows FANIN_REQ_L2_OUT_REG_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fanin_req_arbiter_l2;

  localparam int NC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NC-1:0]        data_req_i   = '0;
  logic [NC-1:0][31:0]  data_add_i   = '0;
  logic [NC-1:0]        data_wen_i   = '0;
  logic [NC-1:0][63:0]  data_wdata_i = '0;
  logic [NC-1:0][7:0]   data_be_i    = '0;
  logic [NC-1:0][15:0]  data_ID_i    = '0;
  logic                 data_gnt_i   = 1'b0;
  logic [NC-1:0]        data_gnt_o;
  logic                 data_req_o;
  logic [31:0]          data_add_o;
  logic                 data_wen_o;
  logic [63:0]          data_wdata_o;
  logic [7:0]           data_be_o;
  logic [15:0]          data_ID_o;

  logic [2:0]           r3_req_i   = '0;
  logic [2:0][7:0]      r3_add_i   = '0;
  logic [2:0]           r3_wen_i   = '0;
  logic [2:0][7:0]      r3_wdata_i = '0;
  logic [2:0][0:0]      r3_be_i    = '0;
  logic [2:0][7:0]      r3_ID_i    = '0;
  logic                 r3_gnt_i   = 1'b0;
  logic [2:0]           r3_gnt_o;
  logic                 r3_req_o;
  logic [7:0]           r3_add_o;
  logic                 r3_wen_o;
  logic [7:0]           r3_wdata_o;
  logic [0:0]           r3_be_o;
  logic [7:0]           r3_ID_o;

  fanin_req_arbiter_l2 #(
    .N_CH(NC), .ADDR_WIDTH(32), .ID_WIDTH(16), .DATA_WIDTH(64), .BE_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_gnt_o(data_gnt_o), .data_req_o(data_req_o), .data_add_o(data_add_o),
    .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
    .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i)
  );

  fanin_req_arbiter_l2 #(
    .N_CH(3), .ADDR_WIDTH(8), .ID_WIDTH(8), .DATA_WIDTH(8), .BE_WIDTH(1)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(r3_req_i), .data_add_i(r3_add_i), .data_wen_i(r3_wen_i),
    .data_wdata_i(r3_wdata_i), .data_be_i(r3_be_i), .data_ID_i(r3_ID_i),
    .data_gnt_o(r3_gnt_o), .data_req_o(r3_req_o), .data_add_o(r3_add_o),
    .data_wen_o(r3_wen_o), .data_wdata_o(r3_wdata_o), .data_be_o(r3_be_o),
    .data_ID_o(r3_ID_o), .data_gnt_i(r3_gnt_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Current (not yet granted) beat offered by each master
  logic [31:0] cur_add   [NC];
  logic        cur_wen   [NC];
  logic [63:0] cur_wdata [NC];
  logic [7:0]  cur_be    [NC];
  logic [15:0] cur_id    [NC];
  int          beat      [NC];

  // Behavioural model state
  int          m_ptr;
  bit          m_lock;
  int          m_lock_idx;
  bit          m_pv;
  logic [31:0] m_add;
  logic        m_wen;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;
  logic [15:0] m_id;

  // Per-cycle bookkeeping between check and model update
  int          ck_w;
  bit          ck_g;
  bit          ck_rst;
  int          last_gidx;
  logic [3:0]  obs_gnt;
  logic        obs_req;
  logic [31:0] obs_add;
  logic [2:0]  obs3_gnt;
  logic [2:0]  nxt_r3_req = '0;
  logic        nxt_r3_gnt = 1'b0;

  logic [15:0] sent_ids[$];
  logic [15:0] bank_ids[$];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic newBeat(input int c);
    beat[c]++;
    cur_add[c]   = $urandom;
    cur_wen[c]   = 1'($urandom);
    cur_wdata[c] = {$urandom, $urandom};
    cur_be[c]    = 8'($urandom);
    cur_id[c]    = {4'(c), 12'(beat[c])};
  endtask

  task automatic modelReset();
    m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_pv = 0;
    m_add = '0; m_wen = 1'b0; m_wdata = '0; m_be = '0; m_id = '0;
  endtask

  // Who should own the port: a still-requesting locked channel first, else
  // the first requester counting up from the pointer (mod NC). -1 = nobody.
  function automatic int modelWinner(input logic [3:0] r);
`ifndef FANIN_REQ_L2_OUT_REG_EN
    if (m_lock && r[m_lock_idx]) return m_lock_idx;
`endif
    for (int k = 0; k < NC; k++) begin
      if (r[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input logic g, input logic rst);
    rst_n = rst;
    if (!rst) modelReset();
    data_req_i = r;
    data_gnt_i = g;
    for (int c = 0; c < NC; c++) begin
      data_add_i[c]   = cur_add[c];
      data_wen_i[c]   = cur_wen[c];
      data_wdata_i[c] = cur_wdata[c];
      data_be_i[c]    = cur_be[c];
      data_ID_i[c]    = cur_id[c];
    end
    r3_req_i = nxt_r3_req;
    r3_gnt_i = nxt_r3_gnt;
  endtask

  task automatic checkOutput();
    logic [3:0]  eg;
    logic        er;
    logic [31:0] ea;
    logic        ew;
    logic [63:0] ed;
    logic [7:0]  eb;
    logic [15:0] ei;
    int          src;
    ck_rst = rst_n;
    ck_g   = data_gnt_i;
    ck_w   = modelWinner(data_req_i);
    eg     = '0;
`ifdef FANIN_REQ_L2_OUT_REG_EN
    if (ck_w >= 0 && (!m_pv || ck_g)) eg[ck_w] = 1'b1;
    er = m_pv; ea = m_add; ew = m_wen; ed = m_wdata; eb = m_be; ei = m_id;
`else
    src = (ck_w >= 0) ? ck_w : m_ptr;
    if (ck_w >= 0 && ck_g) eg[ck_w] = 1'b1;
    er = (ck_w >= 0);
    ea = cur_add[src]; ew = cur_wen[src]; ed = cur_wdata[src]; eb = cur_be[src]; ei = cur_id[src];
`endif
    checkVal("gnt_o", 64'(data_gnt_o), 64'(eg));
    checkVal("req_o", 64'(data_req_o), 64'(er));
    checkVal("add_o", 64'(data_add_o), 64'(ea));
    checkVal("wen_o", 64'(data_wen_o), 64'(ew));
    checkVal("wdata_o", data_wdata_o, ed);
    checkVal("be_o", 64'(data_be_o), 64'(eb));
    checkVal("id_o", 64'(data_ID_o), 64'(ei));
    obs_gnt  = data_gnt_o;
    obs_req  = data_req_o;
    obs_add  = data_add_o;
    obs3_gnt = r3_gnt_o;
    if (rst_n && data_req_o && data_gnt_i) bank_ids.push_back(data_ID_o);
  endtask

  task automatic updateModel();
    last_gidx = -1;
    if (!ck_rst) begin
      modelReset();
      return;
    end
`ifdef FANIN_REQ_L2_OUT_REG_EN
    if (ck_w >= 0 && (!m_pv || ck_g)) begin
      m_add = cur_add[ck_w]; m_wen = cur_wen[ck_w]; m_wdata = cur_wdata[ck_w];
      m_be = cur_be[ck_w]; m_id = cur_id[ck_w];
      m_pv = 1; m_ptr = (ck_w + 1) % NC; last_gidx = ck_w;
    end else if (ck_g) begin
      m_pv = 0;
    end
`else
    if (ck_w >= 0) begin
      if (ck_g) begin
        m_ptr = (ck_w + 1) % NC; m_lock = 0; last_gidx = ck_w;
      end else begin
        m_lock = 1; m_lock_idx = ck_w;
      end
    end
`endif
    if (last_gidx >= 0) begin
      sent_ids.push_back(cur_id[last_gidx]);
      newBeat(last_gidx);
    end
  endtask

  // One clock: drive after the falling edge, check before the rising edge,
  // then advance the model across the rising edge.
  task automatic step(input logic [3:0] r, input logic g, input logic rst);
    @(negedge clk);
    applyStimulus(r, g, rst);
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
  endtask

  task automatic doReset();
    step(4'b0000, 1'b0, 1'b0);
    checkVal("rst_req", 64'(obs_req), 64'd0);
    checkVal("rst_gnt", 64'(obs_gnt), 64'd0);
    step(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a_saved;
    logic [3:0]  want;
    logic [3:0]  rq;
    int          d;

    for (int c = 0; c < NC; c++) begin
      beat[c] = 0;
      newBeat(c);
    end
    for (int c = 0; c < 3; c++) begin
      r3_add_i[c]   = 8'(16 * c + 1);
      r3_wen_i[c]   = 1'b1;
      r3_wdata_i[c] = 8'(c);
      r3_be_i[c]    = 1'b1;
      r3_ID_i[c]    = 8'(c);
    end
    modelReset();

    $display("[TB] test 1: all channels, continuous grant");
    doReset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1, 1'b1);
      checkVal("t1_order", 64'(obs_gnt), 64'(4'b0001 << (i % 4)));
    end

    $display("[TB] test 2: three channels, ch0 and ch2");
    doReset();
    for (int i = 0; i < 6; i++) begin
      nxt_r3_req = 3'b101;
      nxt_r3_gnt = 1'b1;
      step(4'b0000, 1'b0, 1'b1);
      checkVal("t2_order", 64'(obs3_gnt), (i % 2 == 0) ? 64'd1 : 64'd4);
    end
    nxt_r3_req = 3'b000;
    nxt_r3_gnt = 1'b0;

`ifndef FANIN_REQ_L2_OUT_REG_EN
    $display("[TB] test 3: stalled ch1 keeps the port");
    doReset();
    a_saved = cur_add[1];
    step(4'b0010, 1'b0, 1'b1);
    checkVal("t3_add0", 64'(obs_add), 64'(a_saved));
    step(4'b0010, 1'b0, 1'b1);
    checkVal("t3_add1", 64'(obs_add), 64'(a_saved));
    step(4'b0011, 1'b0, 1'b1);
    checkVal("t3_add2", 64'(obs_add), 64'(a_saved));
    step(4'b0011, 1'b1, 1'b1);
    checkVal("t3_gnt", 64'(obs_gnt), 64'b0010);
    step(4'b0011, 1'b1, 1'b1);
    checkVal("t3_next", 64'(obs_gnt), 64'b0001);

    $display("[TB] test 4: locked channel drops its request");
    doReset();
    step(4'b0100, 1'b0, 1'b1);
    a_saved = cur_add[3];
    step(4'b1000, 1'b1, 1'b1);
    checkVal("t4_gnt", 64'(obs_gnt), 64'b1000);
    checkVal("t4_add", 64'(obs_add), 64'(a_saved));
    step(4'b0101, 1'b1, 1'b1);
    checkVal("t4_unlock", 64'(obs_gnt), 64'b0001);
`endif

    $display("[TB] test 5: reset during a stall");
    doReset();
    step(4'b0010, 1'b1, 1'b1);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0101, 1'b1, 1'b0);
    checkVal("t5_in_reset", 64'(obs_gnt), 64'b0001);
    step(4'b0101, 1'b1, 1'b1);
    checkVal("t5_after", 64'(obs_gnt), 64'b0001);

`ifdef FANIN_REQ_L2_OUT_REG_EN
    $display("[TB] test 6: output slice latency and beat order");
    doReset();
    sent_ids.delete();
    bank_ids.delete();
    step(4'b0011, 1'b1, 1'b1);
    checkVal("t6_req_lat0", 64'(obs_req), 64'd0);
    checkVal("t6_first_gnt", 64'(obs_gnt), 64'b0001);
    step(4'b0011, 1'b0, 1'b1);
    checkVal("t6_req_lat1", 64'(obs_req), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0011, (i % 2 == 0), 1'b1);
    end
    checkVal("t6_bank_beats", 64'(bank_ids.size()), 64'd5);
    d = sent_ids.size() - bank_ids.size();
    checkVal("t6_pending", 64'(d), 64'd1);
    for (int i = 0; i < bank_ids.size(); i++) begin
      checkVal("t6_id", 64'(bank_ids[i]), 64'(sent_ids[i]));
      checkVal("t6_chan", 64'(bank_ids[i][15:12]), 64'(i % 2));
    end
`endif

    $display("[TB] random traffic");
    doReset();
    want = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        if (want[c]) begin
          if ($urandom_range(0, 19) == 0) want[c] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          want[c] = 1'b1;
        end
      end
      rq = want;
      step(rq, ($urandom_range(0, 9) < 7), (i != 150));
      if (last_gidx >= 0) want[last_gidx] = ($urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
